// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector.
// Tracks the matched prefix length of PATTERN with a KMP-style automaton,
// flags matches in Moore or Mealy style (runtime selectable), supports
// overlapping or non-overlapping detection and keeps a saturating match count.
module seq_detector_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter int             CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     step,
    input  logic                     X,
    input  logic                     M,
    input  logic                     OVL,
    output logic                     Z,
    output logic [$clog2(N+1)-1:0]   Q,
    output logic [CNT_W-1:0]         count
);

    localparam int QW = $clog2(N + 1);
    localparam logic [QW-1:0]    FULL    = QW'(N);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Bit i of the pattern in arrival order (i = 0 is the first bit received).
    function automatic logic pat_bit(input int i);
        logic [N-1:0] sh;
        sh = PATTERN >> (N - 1 - i);
        return sh[0];
    endfunction

    // Longest proper prefix of the full pattern that is also its suffix.
    function automatic logic [QW-1:0] fail_full();
        int   best;
        logic ok;
        best = 0;
        for (int l = 1; l < N; l++) begin
            ok = 1'b1;
            for (int j = 0; j < N; j++) begin
                if (j < l) begin
                    ok = ok & (pat_bit(j) == pat_bit(N - l + j));
                end else begin
                    ok = ok;
                end
            end
            if (ok) begin
                best = l;
            end else begin
                best = best;
            end
        end
        return QW'(best);
    endfunction

    localparam logic [QW-1:0] FAIL_N = fail_full();

    // Longest pattern prefix that is a suffix of (prefix of length b, then x).
    // Candidates are scanned shortest first so the longest match wins.
    function automatic logic [QW-1:0] next_k(input logic [QW-1:0] b, input logic x);
        int   bi;
        int   idx;
        int   res;
        logic ok;
        logic sbit;
        bi  = int'(b);
        res = 0;
        for (int l = 1; l <= N; l++) begin
            if (l <= bi + 1) begin
                ok = 1'b1;
                for (int j = 0; j < N; j++) begin
                    if (j < l) begin
                        idx  = bi + 1 - l + j;
                        sbit = (idx < bi) ? pat_bit(idx) : x;
                        ok   = ok & (sbit == pat_bit(j));
                    end else begin
                        ok = ok;
                    end
                end
                if (ok) begin
                    res = l;
                end else begin
                    res = res;
                end
            end else begin
                res = res;
            end
        end
        return QW'(res);
    endfunction

    logic [QW-1:0]    k_r;
    logic [CNT_W-1:0] count_r;
    logic             full_r;
    logic [QW-1:0]    base_s;
    logic [QW-1:0]    k_next_s;
    logic             hit_s;
    logic             mealy_s;

    // Next-state decode: choose the restart base, then extend it by X.
    always_comb begin
        base_s = k_r;
        if (k_r == FULL) begin
            base_s = OVL ? FAIL_N : {QW{1'b0}};
        end else begin
            base_s = k_r;
        end
        k_next_s = next_k(base_s, X);
        hit_s    = (k_next_s == FULL);
        mealy_s  = step & ~reset & hit_s;
    end

    // State, Moore flag and saturating match counter; reset wins over step.
    always_ff @(posedge clk) begin
        if (reset) begin
            k_r     <= {QW{1'b0}};
            full_r  <= 1'b0;
            count_r <= {CNT_W{1'b0}};
        end else if (step) begin
            k_r    <= k_next_s;
            full_r <= hit_s;
            if (hit_s && (count_r != CNT_MAX)) begin
                count_r <= count_r + CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end else begin
            k_r     <= k_r;
            full_r  <= full_r;
            count_r <= count_r;
        end
    end

    assign Z     = M ? mealy_s : full_r;
    assign Q     = k_r;
    assign count = count_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: reset, overlap/non-overlap,
// Mealy/Moore decode, mid-pattern reset and counter saturation.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset, step, X, M, OVL;
    logic       Z, Z2;
    logic [2:0] Q, Q2;
    logic [7:0] count;
    logic [1:0] count2;
    int         passed = 0;
    int         total  = 0;
    int         fails  = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.N(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .step(step), .X(X), .M(M), .OVL(OVL),
        .Z(Z), .Q(Q), .count(count)
    );

    seq_detector_param #(.N(4), .PATTERN(4'b1011), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .step(step), .X(X), .M(M), .OVL(OVL),
        .Z(Z2), .Q(Q2), .count(count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one bit with step=1 and advance to the next falling edge.
    task automatic send(input logic b);
        step = 1'b1;
        X    = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        step = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        step  = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [6:0] bits7;
    int qovl[7]   = '{1, 2, 3, 4, 2, 3, 4};
    int zovl[7]   = '{0, 0, 0, 1, 0, 0, 1};
    int qnovl[7]  = '{1, 2, 3, 4, 0, 1, 1};
    int znovl[7]  = '{0, 0, 0, 1, 0, 0, 0};
    int csat[6]   = '{1, 2, 3, 3, 3, 3};

    initial begin
        reset = 1'b1; step = 1'b0; X = 1'b0; M = 1'b0; OVL = 1'b1;
        repeat (2) @(negedge clk);

        // Reset with step and X held high: nothing consumed
        step = 1'b1; X = 1'b1;
        @(negedge clk);
        chk("rst_q", Q, 0);
        chk("rst_count", count, 0);
        chk("rst_z_moore", Z, 0);
        M = 1'b1; #1;
        chk("rst_z_mealy", Z, 0);
        M = 1'b0;
        reset = 1'b0; step = 1'b0;
        @(negedge clk);
        chk("rst_no_consume_q", Q, 0);

        // Overlapping, Moore: 1011011
        bits7 = 7'b1011011;
        OVL = 1'b1; M = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send(bits7[6-i]);
            chk($sformatf("ovl_q%0d", i), Q, qovl[i]);
            chk($sformatf("ovl_z%0d", i), Z, zovl[i]);
        end
        idle(1);
        chk("ovl_count", count, 2);
        chk("ovl_hold_q", Q, 4);

        // Non-overlapping: same bits
        do_reset();
        OVL = 1'b0;
        for (int i = 0; i < 7; i++) begin
            send(bits7[6-i]);
            chk($sformatf("novl_q%0d", i), Q, qnovl[i]);
            chk($sformatf("novl_z%0d", i), Z, znovl[i]);
        end
        idle(1);
        chk("novl_count", count, 1);

        // Mealy, overlapping: 1,0,1,1
        do_reset();
        OVL = 1'b1; M = 1'b1;
        send(1'b1);
        send(1'b0);
        step = 1'b1; X = 1'b1; #1;
        chk("mealy_z_step3", Z, 0);
        @(negedge clk);
        step = 1'b1; X = 1'b1; #1;
        chk("mealy_z_step4", Z, 1);
        chk("mealy_q_before", Q, 3);
        @(negedge clk);
        step = 1'b0; #1;
        chk("mealy_z_after", Z, 0);
        chk("mealy_q_after", Q, 4);
        M = 1'b0; #1;
        chk("m_toggle_z", Z, 1);
        @(negedge clk);
        chk("m_toggle_q", Q, 4);
        chk("m_toggle_count", count, 1);

        // Reset mid-pattern abandons the partial match
        do_reset();
        send(1'b1);
        send(1'b0);
        send(1'b1);
        do_reset();
        send(1'b1);
        idle(1);
        chk("midrst_q", Q, 1);
        chk("midrst_count", count, 0);

        // Counter saturation with CNT_W=2, six back-to-back overlapping matches
        do_reset();
        OVL = 1'b1; M = 1'b0;
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        chk("sat_count0", count2, csat[0]);
        chk("sat_z0", Z2, 1);
        for (int m = 1; m < 6; m++) begin
            send(1'b0); send(1'b1); send(1'b1);
            chk($sformatf("sat_count%0d", m), count2, csat[m]);
            chk($sformatf("sat_z%0d", m), Z2, 1);
        end
        idle(1);
        chk("sat_wide_count", count, 6);
        chk("sat_q", Q2, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector, the successor to the lab's fixed 3-bit Moore/Mealy sequence detector. Samples one data bit per `step` pulse (the single-cycle output of the one-shot) in the system clock domain, tracks the matched prefix length with a KMP-style automaton, and flags pattern matches in runtime-selectable Moore or Mealy style with optional overlapping detection. Adds a saturating match counter for display. Sits between the one-shot and the display/LED logic in the top level.

## Interface
Parameters:
- `N`, 4, pattern length in bits; legal range 2..16.
- `PATTERN`, 4'b1011, N-bit target pattern; `PATTERN[N-1]` is the first bit received.
- `CNT_W`, 8, match counter width.

Ports:
- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `step`  input  1  single-cycle sample enable; X is consumed only when step=1.
- `X`  input  1  serial data bit.
- `M`  input  1  output mode: 0 = Moore, 1 = Mealy.
- `OVL`  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
- `Z`  output  1  match flag.
- `Q`  output  $clog2(N+1)  current state = matched prefix length k, 0..N.
- `count`  output  CNT_W  number of matches since reset, saturating.

## Operation
- State k = length of the longest prefix of PATTERN equal to a suffix of the bits accepted since the last restart point; k=N means a full match was just completed.
- Failure function f(l), computed at elaboration: length of the longest proper prefix of PATTERN[N-1 -: l] that is also its suffix.
- Transition on step=1: base b = k if k<N; if k==N, b = f(N) when OVL=1, b = 0 when OVL=0. Next k' = longest l ≤ N with PATTERN prefix of length l equal to suffix of (prefix of length b followed by X). Implement as a full next-state table or a KMP fallback chain; results must be identical.
- step=0: Q, count hold.
- Match event: a step that makes k' = N. `count` increments by 1 on each match event, holding at 2^CNT_W−1 (no wrap).
- Moore (M=0): Z = (Q == N).
- Mealy (M=1): Z = step & ~reset & (k' == N), combinational from Q, X, step.
- M affects only the Z decode; toggling M never changes Q or count. OVL is sampled only at the step that leaves state N.

## Timing
- Reset: Q=0, count=0, Z=0 in both modes. Reset beats a simultaneous step (the step is discarded).
- Latency: Q/count update on the clk edge that samples step=1. Moore Z rises in the cycle after that edge and holds until the next step that leaves N. Mealy Z is high during the step=1 cycle itself and lasts exactly one cycle per match when step is a one-cycle pulse.
- Step on consecutive cycles is legal: one bit per cycle, no bubbles required.
- Reset mid-pattern abandons the partial match: the next accepted bit is treated as the first bit.
- Count saturation: at max value, further matches leave count unchanged, while Z still asserts.

## Test plan
- Reset with step=1, X=1 held high → Q=0, count=0, Z=0 on the following cycle; no bit consumed.
- PATTERN=1011, OVL=1, M=0, bits 1,0,1,1,0,1,1 → Q sequence 1,2,3,4,2,3,4; Z high after steps 4 and 7; count=2.
- Same bits with OVL=0 → Q sequence 1,2,3,4,0,1,1; single match; count=1.
- Mealy (M=1), OVL=1, bits 1,0,1,1 → Z high only during the 4th step cycle, low the cycle after; Q=4. Toggle M to 0 with step=0 → Z goes high, Q still 4, count unchanged.
- Bits 1,0,1 then reset then 1 → Q=1 (not 4); count=0.
- CNT_W=2, OVL=1, six back-to-back matches of 1011 → count reads 1,2,3,3,3,3; Moore Z asserts after every match.
